// File: rtl/imem_loader.sv
// Loads a framed program image (16-bit word count + big-endian 32-bit words)
// from a byte stream into instruction memory, holding the CPU in reset until done.
module imem_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int         DEPTH   = 2**ADDR_W;
   localparam logic [16:0] DEPTH_N = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_HDR_HI, S_HDR_LO, S_DATA, S_WR, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         n_q, n_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
   logic [23:0]         word_buf_q, word_buf_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic [ADDR_W:0]     words_loaded_q, words_loaded_d;

   logic        accept;
   logic [15:0] n_full;

   assign in_ready = ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)) && !restart;
   assign accept   = in_valid && in_ready;
   assign n_full   = {n_q[15:8], in_data};

   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      byte_cnt_d     = byte_cnt_q;
      word_idx_d     = word_idx_q;
      word_buf_d     = word_buf_q;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      words_loaded_d = words_loaded_q;
      if (restart) begin
         state_d        = S_HDR_HI;
         n_d            = '0;
         byte_cnt_d     = '0;
         word_idx_d     = '0;
         words_loaded_d = '0;
      end else begin
         case (state_q)
            S_HDR_HI: if (accept) begin
               n_d     = {in_data, 8'h00};
               state_d = S_HDR_LO;
            end
            S_HDR_LO: if (accept) begin
               n_d        = n_full;
               byte_cnt_d = '0;
               word_idx_d = '0;
               if ((n_full == 16'd0) || ({1'b0, n_full} > DEPTH_N))
                  state_d = S_ERR;
               else
                  state_d = S_DATA;
            end
            S_DATA: if (accept) begin
               if (byte_cnt_q == 2'd3) begin
                  // Latch the full word so WR drives registered address/data.
                  wr_data_d  = {word_buf_q, in_data};
                  wr_addr_d  = word_idx_q;
                  byte_cnt_d = '0;
                  state_d    = S_WR;
               end else begin
                  word_buf_d = {word_buf_q[15:0], in_data};
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
            S_WR: begin
               words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
               if (16'(word_idx_q) == (n_q - 16'd1)) begin
                  state_d = S_DONE;
               end else begin
                  word_idx_d = word_idx_q + ADDR_W'(1);
                  state_d    = S_DATA;
               end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_HDR_HI;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_HDR_HI;
         n_q            <= '0;
         byte_cnt_q     <= '0;
         word_idx_q     <= '0;
         word_buf_q     <= '0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         byte_cnt_q     <= byte_cnt_d;
         word_idx_q     <= word_idx_d;
         word_buf_q     <= word_buf_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign wr_en        = (state_q == S_WR);
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign cpu_reset    = (state_q != S_DONE);
   assign busy         = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                         (state_q == S_DATA)   || (state_q == S_WR);
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: header vector table plus scoreboarded image loads,
// stream gaps, restart and asynchronous reset corner cases.
module tb_imem_loader;

   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              restart = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .restart(restart),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct packed {
      logic [15:0] n;
      logic        exp_err;
   } hdr_vec_t;

   wr_t      exp_q[$];
   hdr_vec_t vecs[6];
   int       n_checks = 0;
   int       n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset && wr_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", wr_addr, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", wr_data, e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      #1;
      budget = 0;
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         #1;
         budget++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready 0 for byte %h, required 1", b);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input bit gaps);
      wr_t e;
      e.addr = a;
      e.data = w;
      for (int k = 3; k >= 0; k--) begin
         if (k == 0) exp_q.push_back(e);
         send_byte(w[k*8 +: 8], gaps ? int'($urandom_range(1, 3)) : 0);
      end
      @(negedge clk);
      check("wr_latency", 32'(wr_en), 32'd1);
   endtask

   task automatic send_hdr(input logic [15:0] n);
      send_byte(n[15:8], 0);
      send_byte(n[7:0], 0);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      #1 check("ready_in_restart", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 restart = 1'b0;
   endtask

   task automatic check_done(input int nw);
      @(negedge clk);
      check("done", 32'(done), 32'd1);
      check("cpu_reset_low", 32'(cpu_reset), 32'd0);
      check("words_loaded", 32'(words_loaded), 32'(nw));
      check("busy_done", 32'(busy), 32'd0);
      check("ready_done", 32'(in_ready), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] fib[6];
      vecs[0] = '{n: 16'h0000, exp_err: 1'b1};
      vecs[1] = '{n: 16'h0041, exp_err: 1'b1};
      vecs[2] = '{n: 16'h0100, exp_err: 1'b1};
      vecs[3] = '{n: 16'hFFFF, exp_err: 1'b1};
      vecs[4] = '{n: 16'h0001, exp_err: 1'b0};
      vecs[5] = '{n: 16'h0040, exp_err: 1'b0};
      fib = '{32'd6765, 32'd10946, 32'd17711, 32'd28657, 32'd46368, 32'd75025};

      // Reset state
      #3 reset = 1'b0;
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_ready", 32'(in_ready), 32'd1);

      // Six-word Fibonacci image
      send_hdr(16'h0006);
      for (int i = 0; i < 5; i++) send_word(ADDR_W'(i), fib[i], 1'b0);
      for (int k = 3; k >= 0; k--) begin
         if (k == 0) exp_q.push_back('{addr: ADDR_W'(5), data: fib[5]});
         send_byte(fib[5][k*8 +: 8], 0);
      end
      @(negedge clk);
      check("last_wr_en", 32'(wr_en), 32'd1);
      check("cpu_reset_during_last_wr", 32'(cpu_reset), 32'd1);
      check("done_during_last_wr", 32'(done), 32'd0);
      check_done(6);
      // Bytes offered in DONE are ignored
      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      check("done_ignores_bytes", 32'(words_loaded), 32'd6);

      // Header vector table
      foreach (vecs[i]) begin
         do_restart();
         send_hdr(vecs[i].n);
         @(negedge clk);
         check("hdr_error", 32'(error), 32'(vecs[i].exp_err));
         check("hdr_cpu_reset", 32'(cpu_reset), 32'd1);
         check("hdr_ready", 32'(in_ready), 32'(!vecs[i].exp_err));
         check("hdr_busy", 32'(busy), 32'(!vecs[i].exp_err));
      end

      // Full-depth image, N = DEPTH
      do_restart();
      send_hdr(16'h0040);
      for (int i = 0; i < 64; i++) send_word(ADDR_W'(i), $urandom, 1'b0);
      check_done(64);

      // Input gaps inside the middle word
      do_restart();
      send_hdr(16'h0003);
      send_word(ADDR_W'(0), 32'h01234567, 1'b0);
      send_word(ADDR_W'(1), 32'h89ABCDEF, 1'b1);
      send_word(ADDR_W'(2), 32'hF0E1D2C3, 1'b0);
      check_done(3);

      // Restart part-way through word 1 with a byte on offer
      do_restart();
      send_hdr(16'h0002);
      send_word(ADDR_W'(0), 32'hCAFEF00D, 1'b0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      restart  = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h99;
      #1 check("ready_in_restart_valid", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      restart  = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("restart_words", 32'(words_loaded), 32'd0);
      check("restart_ready", 32'(in_ready), 32'd1);
      check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
      send_hdr(16'h0001);
      send_word(ADDR_W'(0), 32'h12345678, 1'b0);
      check_done(1);

      // Asynchronous reset in the middle of DATA
      do_restart();
      send_hdr(16'h0002);
      send_word(ADDR_W'(0), 32'h0BADBEEF, 1'b0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_wr_en", 32'(wr_en), 32'd0);
      check("arst_wr_addr", 32'(wr_addr), 32'd0);
      check("arst_wr_data", wr_data, 32'd0);
      check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("arst_done", 32'(done), 32'd0);
      check("arst_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("arst_ready", 32'(in_ready), 32'd1);
      check("arst_busy", 32'(busy), 32'd1);
      send_hdr(16'h0001);
      send_word(ADDR_W'(0), 32'hAABBCCDD, 1'b0);
      check_done(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
